// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS32 execute stage.
//   Bus widths, aluop/alusel encodings, MADD-family FSM states and a
//   leading-zero counter used by CLZ/CLO.
package ex_pkg;

    localparam int REG_BUS    = 32;
    localparam int REG_ADDR   = 5;
    localparam int DOUBLE_BUS = 64;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MUL   = 3'b101;

    localparam logic [7:0] OP_NOP   = 8'b00000000;
    localparam logic [7:0] OP_AND   = 8'b00100100;
    localparam logic [7:0] OP_OR    = 8'b00100101;
    localparam logic [7:0] OP_XOR   = 8'b00100110;
    localparam logic [7:0] OP_NOR   = 8'b00100111;
    localparam logic [7:0] OP_SLL   = 8'b01111100;
    localparam logic [7:0] OP_SRL   = 8'b00000010;
    localparam logic [7:0] OP_SRA   = 8'b00000011;
    localparam logic [7:0] OP_SLT   = 8'b00101010;
    localparam logic [7:0] OP_SLTU  = 8'b00101011;
    localparam logic [7:0] OP_ADD   = 8'b00100000;
    localparam logic [7:0] OP_ADDU  = 8'b00100001;
    localparam logic [7:0] OP_SUB   = 8'b00100010;
    localparam logic [7:0] OP_SUBU  = 8'b00100011;
    localparam logic [7:0] OP_ADDI  = 8'b01010101;
    localparam logic [7:0] OP_ADDIU = 8'b01010110;
    localparam logic [7:0] OP_CLZ   = 8'b10110000;
    localparam logic [7:0] OP_CLO   = 8'b10110001;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_MUL   = 8'b10101001;
    localparam logic [7:0] OP_MADD  = 8'b10100110;
    localparam logic [7:0] OP_MADDU = 8'b10101000;
    localparam logic [7:0] OP_MSUB  = 8'b10101010;
    localparam logic [7:0] OP_MSUBU = 8'b10101011;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;
    localparam logic [7:0] OP_MOVZ  = 8'b00001010;
    localparam logic [7:0] OP_MOVN  = 8'b00001011;
    localparam logic [7:0] OP_MFHI  = 8'b00010000;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MFLO  = 8'b00010010;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;

    typedef enum logic {
        EX_ST_IDLE = 1'b0,
        EX_ST_ACC  = 1'b1
    } ex_state_t;

    // Highest set bit wins, so the final count reflects the leading zeros.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) c = 6'(31 - i);
        return c;
    endfunction

endpackage

// File: rtl/ex_mul.sv
// ex_mul: combinational DW x DW multiplier, signed or unsigned.
//   a, b      operands
//   signed_i  1 = treat operands as two's complement
//   p         2*DW-bit product
// Signed products use magnitude multiply followed by a conditional negate.
module ex_mul #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            signed_i,
    output logic [2*DW-1:0] p
);

    logic          neg_a, neg_b;
    logic [DW-1:0] mag_a, mag_b;
    logic [2*DW-1:0] up;

    assign neg_a = signed_i & a[DW-1];
    assign neg_b = signed_i & b[DW-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;
    assign up    = {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
    assign p     = (neg_a ^ neg_b) ? -up : up;

endmodule

// File: rtl/ex.sv
// ex: MIPS32 execute stage (logic, shift, arith, move, multiply, MADD family).
//   clk, rst (async, active-low)
//   aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i   decoded instruction
//   hi_i/lo_i, mem_*, wb_*                             HI/LO with forwarding
//   stall_i                                            stage held downstream
//   wd_o, wreg_o, wdata_o                              GPR write
//   whilo_o, hi_o, lo_o                                HI/LO write
//   ov_o                                               signed overflow
//   stallreq_from_ex                                   first MADD-family cycle
// Optional: EX_OVF_TRAP_EN suppresses the GPR write on ADD/ADDI/SUB overflow.
module ex
    import ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    aluop_i,
    input  logic [2:0]    alusel_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    input  logic [AW-1:0] wd_i,
    input  logic          wreg_i,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    input  logic          mem_whilo_i,
    input  logic [DW-1:0] mem_hi_i,
    input  logic [DW-1:0] mem_lo_i,
    input  logic          wb_whilo_i,
    input  logic [DW-1:0] wb_hi_i,
    input  logic [DW-1:0] wb_lo_i,
    input  logic          stall_i,
    output logic [AW-1:0] wd_o,
    output logic          wreg_o,
    output logic [DW-1:0] wdata_o,
    output logic          whilo_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          ov_o,
    output logic          stallreq_from_ex
);

    logic [DW-1:0]   hi_f, lo_f, b2, sum, res;
    logic [2*DW-1:0] prod, hilo_temp, acc;
    logic            is_madd, is_msub, mul_signed, stallreq, commit, ovf;
    ex_state_t       state, state_nx;

    // Youngest HI/LO value wins: mem stage, then wb stage, then committed.
    assign hi_f = mem_whilo_i ? mem_hi_i : wb_whilo_i ? wb_hi_i : hi_i;
    assign lo_f = mem_whilo_i ? mem_lo_i : wb_whilo_i ? wb_lo_i : lo_i;

    assign is_madd    = aluop_i inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign is_msub    = aluop_i inside {OP_MSUB, OP_MSUBU};
    assign mul_signed = aluop_i inside {OP_MUL, OP_MULT, OP_MADD, OP_MSUB};
    assign b2         = (aluop_i inside {OP_SUB, OP_SUBU}) ? -reg2_i : reg2_i;
    assign sum        = reg1_i + b2;
    assign acc        = hilo_temp + {hi_f, lo_f};

    ex_mul #(.DW(DW)) u_mul (
        .a        (reg1_i),
        .b        (reg2_i),
        .signed_i (mul_signed),
        .p        (prod)
    );

`ifdef EX_OVF_TRAP_EN
    assign ovf = (aluop_i inside {OP_ADD, OP_ADDI, OP_SUB}) &&
                 (reg1_i[DW-1] == b2[DW-1]) && (sum[DW-1] != reg1_i[DW-1]);
`else
    assign ovf = 1'b0;
`endif

    assign stallreq = is_madd && state == EX_ST_IDLE;
    assign commit   = is_madd && state == EX_ST_ACC;

    always_comb begin
        state_nx = state;
        if (!stall_i) state_nx = stallreq ? EX_ST_ACC : EX_ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EX_ST_IDLE;
            hilo_temp <= '0;
        end else begin
            state <= state_nx;
            if (stallreq && !stall_i) hilo_temp <= is_msub ? -prod : prod;
        end
    end

    always_comb begin
        res = '0;
        case (aluop_i)
            OP_OR:                               res = reg1_i | reg2_i;
            OP_AND:                              res = reg1_i & reg2_i;
            OP_XOR:                              res = reg1_i ^ reg2_i;
            OP_NOR:                              res = ~(reg1_i | reg2_i);
            OP_SLL:                              res = reg2_i << reg1_i[4:0];
            OP_SRL:                              res = reg2_i >> reg1_i[4:0];
            OP_SRA:                              res = $signed(reg2_i) >>> reg1_i[4:0];
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU,
            OP_SUB, OP_SUBU:                     res = sum;
            OP_SLT:                              res = DW'($signed(reg1_i) < $signed(reg2_i));
            OP_SLTU:                             res = DW'(reg1_i < reg2_i);
            OP_CLZ:                              res = DW'(clz32(reg1_i));
            OP_CLO:                              res = DW'(clz32(~reg1_i));
            OP_MFHI:                             res = hi_f;
            OP_MFLO:                             res = lo_f;
            OP_MOVN, OP_MOVZ:                    res = reg1_i;
            OP_MUL:                              res = prod[DW-1:0];
            default:                             res = '0;
        endcase
    end

    always_comb begin
        wd_o             = wd_i;
        wreg_o           = wreg_i && !(aluop_i inside {OP_MULT, OP_MULTU}) && !ovf;
        wdata_o          = (alusel_i == SEL_NOP) ? '0 : res;
        ov_o             = ovf;
        stallreq_from_ex = stallreq;
        whilo_o          = 1'b0;
        {hi_o, lo_o}     = '0;
        if (aluop_i == OP_MTHI) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = {reg1_i, lo_f};
        end else if (aluop_i == OP_MTLO) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = {hi_f, reg1_i};
        end else if (aluop_i inside {OP_MULT, OP_MULTU}) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = prod;
        end else if (commit) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = acc;
        end
        if (!rst) begin
            wd_o             = '0;
            wreg_o           = 1'b0;
            wdata_o          = '0;
            ov_o             = 1'b0;
            stallreq_from_ex = 1'b0;
            whilo_o          = 1'b0;
            {hi_o, lo_o}     = '0;
        end
    end

endmodule

// File: tb/tb_ex.sv
// tb_ex: directed self-checking bench for the ex execute stage.
module tb_ex;
    import ex_pkg::*;

    logic        clk, rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i, mem_whilo_i, wb_whilo_i, stall_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, ov_o, stallreq_from_ex;
    logic [31:0] wdata_o, hi_o, lo_o;
    int          checks, failures, commits;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .stall_i(stall_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .ov_o(ov_o),
        .stallreq_from_ex(stallreq_from_ex)
    );

    always #5 clk = ~clk;

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
        #1;
    endtask

    task automatic test_reset;
        rst = 0;
        set_op(OP_MULT, SEL_LOGIC, 32'h0000FF00, 32'h0F0F0F0F);
        wd_i = 5'd5; wreg_i = 1;
        #1;
        checks++;
        if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, ov_o, stallreq_from_ex} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h ov=%b stallreq=%b exp all 0",
                     wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, ov_o, stallreq_from_ex);
        end
        rst = 1;
        #1;
    endtask

    task automatic test_logic;
        set_op(OP_OR, SEL_LOGIC, 32'h0000FF00, 32'h0F0F0F0F);
        checks++;
        if (wdata_o !== 32'h0F0FFF0F || wd_o !== 5'd5 || wreg_o !== 1'b1) begin
            failures++;
            $display("FAIL or got wdata=%h wd=%0d wreg=%b exp 0f0fff0f 5 1", wdata_o, wd_o, wreg_o);
        end
        set_op(OP_NOR, SEL_LOGIC, 32'h0000FF00, 32'h0F0F0F0F);
        checks++;
        if (wdata_o !== 32'hF0F000F0) begin
            failures++;
            $display("FAIL nor got %h exp f0f000f0", wdata_o);
        end
    endtask

    task automatic test_shift;
        set_op(OP_SRA, SEL_SHIFT, 32'd4, 32'h80000010);
        checks++;
        if (wdata_o !== 32'hF8000001) begin
            failures++;
            $display("FAIL sra got %h exp f8000001", wdata_o);
        end
        set_op(OP_SRL, SEL_SHIFT, 32'd4, 32'h80000010);
        checks++;
        if (wdata_o !== 32'h08000001) begin
            failures++;
            $display("FAIL srl got %h exp 08000001", wdata_o);
        end
        set_op(OP_SLL, SEL_SHIFT, 32'hFFFFFFE3, 32'h80000011);
        checks++;
        if (wdata_o !== 32'h00000088) begin
            failures++;
            $display("FAIL sll_amt5 got %h exp 00000088", wdata_o);
        end
    endtask

    task automatic test_arith;
        set_op(OP_SLT, SEL_ARITH, 32'hFFFFFFFF, 32'd1);
        checks++;
        if (wdata_o !== 32'd1) begin
            failures++;
            $display("FAIL slt got %h exp 1", wdata_o);
        end
        set_op(OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'd1);
        checks++;
        if (wdata_o !== 32'd0) begin
            failures++;
            $display("FAIL sltu got %h exp 0", wdata_o);
        end
        set_op(OP_SUBU, SEL_ARITH, 32'd5, 32'd7);
        checks++;
        if (wdata_o !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL subu got %h exp fffffffe", wdata_o);
        end
        set_op(OP_CLZ, SEL_ARITH, 32'd0, 32'd0);
        checks++;
        if (wdata_o !== 32'd32) begin
            failures++;
            $display("FAIL clz_zero got %0d exp 32", wdata_o);
        end
        set_op(OP_CLZ, SEL_ARITH, 32'h00010000, 32'd0);
        checks++;
        if (wdata_o !== 32'd15) begin
            failures++;
            $display("FAIL clz got %0d exp 15", wdata_o);
        end
        set_op(OP_CLO, SEL_ARITH, 32'hF0000000, 32'd0);
        checks++;
        if (wdata_o !== 32'd4) begin
            failures++;
            $display("FAIL clo got %0d exp 4", wdata_o);
        end
        set_op(OP_ADDU, SEL_ARITH, 32'h7FFFFFFF, 32'd1);
        checks++;
        if (wreg_o !== 1'b1 || wdata_o !== 32'h80000000 || ov_o !== 1'b0) begin
            failures++;
            $display("FAIL addu_wrap got wreg=%b wdata=%h ov=%b exp 1 80000000 0", wreg_o, wdata_o, ov_o);
        end
        set_op(OP_ADD, SEL_ARITH, 32'h7FFFFFFF, 32'd1);
        checks++;
`ifdef EX_OVF_TRAP_EN
        if (wreg_o !== 1'b0 || ov_o !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf got wreg=%b ov=%b exp 0 1", wreg_o, ov_o);
        end
`else
        if (wreg_o !== 1'b1 || wdata_o !== 32'h80000000 || ov_o !== 1'b0) begin
            failures++;
            $display("FAIL add_ovf got wreg=%b wdata=%h ov=%b exp 1 80000000 0", wreg_o, wdata_o, ov_o);
        end
`endif
    endtask

    task automatic test_move;
        hi_i = 32'd1; wb_whilo_i = 1; wb_hi_i = 32'h5555; mem_whilo_i = 1; mem_hi_i = 32'hAAAA0000;
        set_op(OP_MFHI, SEL_MOVE, 32'd0, 32'd0);
        checks++;
        if (wdata_o !== 32'hAAAA0000) begin
            failures++;
            $display("FAIL mfhi_mem got %h exp aaaa0000", wdata_o);
        end
        mem_whilo_i = 0;
        #1;
        checks++;
        if (wdata_o !== 32'h5555) begin
            failures++;
            $display("FAIL mfhi_wb got %h exp 00005555", wdata_o);
        end
        wb_whilo_i = 0;
        #1;
        checks++;
        if (wdata_o !== 32'd1) begin
            failures++;
            $display("FAIL mfhi_reg got %h exp 00000001", wdata_o);
        end
        lo_i = 32'h99;
        set_op(OP_MTHI, SEL_NOP, 32'h1234, 32'd0);
        checks++;
        if (whilo_o !== 1'b1 || hi_o !== 32'h1234 || lo_o !== 32'h99) begin
            failures++;
            $display("FAIL mthi got whilo=%b hi=%h lo=%h exp 1 1234 99", whilo_o, hi_o, lo_o);
        end
        set_op(OP_MOVN, SEL_MOVE, 32'hCAFE, 32'd1);
        checks++;
        if (wdata_o !== 32'hCAFE || wreg_o !== 1'b1 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL movn got wdata=%h wreg=%b whilo=%b exp cafe 1 0", wdata_o, wreg_o, whilo_o);
        end
        hi_i = 0; lo_i = 0;
    endtask

    task automatic test_mult;
        set_op(OP_MULT, SEL_NOP, 32'hFFFFFFFE, 32'd3);
        checks++;
        if (whilo_o !== 1'b1 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA || wreg_o !== 1'b0) begin
            failures++;
            $display("FAIL mult got whilo=%b hi=%h lo=%h wreg=%b exp 1 ffffffff fffffffa 0", whilo_o, hi_o, lo_o, wreg_o);
        end
        set_op(OP_MULTU, SEL_NOP, 32'hFFFFFFFE, 32'd3);
        checks++;
        if (hi_o !== 32'd2 || lo_o !== 32'hFFFFFFFA) begin
            failures++;
            $display("FAIL multu got hi=%h lo=%h exp 2 fffffffa", hi_o, lo_o);
        end
        set_op(OP_MUL, SEL_MUL, 32'hFFFFFFFE, 32'd3);
        checks++;
        if (wdata_o !== 32'hFFFFFFFA || wreg_o !== 1'b1 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL mul got wdata=%h wreg=%b whilo=%b exp fffffffa 1 0", wdata_o, wreg_o, whilo_o);
        end
    endtask

    task automatic test_unknown;
        set_op(8'hFF, SEL_LOGIC, 32'h1234, 32'h5678);
        checks++;
        if (wdata_o !== 32'd0 || whilo_o !== 1'b0 || wd_o !== 5'd5 || wreg_o !== 1'b1) begin
            failures++;
            $display("FAIL unknown got wdata=%h whilo=%b wd=%0d wreg=%b exp 0 0 5 1", wdata_o, whilo_o, wd_o, wreg_o);
        end
        set_op(OP_DIV, SEL_NOP, 32'd10, 32'd2);
        checks++;
        if (wdata_o !== 32'd0 || whilo_o !== 1'b0 || stallreq_from_ex !== 1'b0) begin
            failures++;
            $display("FAIL div got wdata=%h whilo=%b stallreq=%b exp 0 0 0", wdata_o, whilo_o, stallreq_from_ex);
        end
    endtask

    task automatic test_madd;
        @(posedge clk); #1;
        lo_i = 32'h10; hi_i = 0;
        set_op(OP_MADD, SEL_MUL, 32'hFFFFFFFF, 32'd3);
        checks++;
        if (stallreq_from_ex !== 1'b1 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL madd_c1 got stallreq=%b whilo=%b exp 1 0", stallreq_from_ex, whilo_o);
        end
        @(posedge clk); #1;
        checks++;
        if (stallreq_from_ex !== 1'b0 || whilo_o !== 1'b1 || hi_o !== 32'd0 || lo_o !== 32'hD) begin
            failures++;
            $display("FAIL madd_c2 got stallreq=%b whilo=%b hi=%h lo=%h exp 0 1 0 d", stallreq_from_ex, whilo_o, hi_o, lo_o);
        end
        @(posedge clk); #1;
        set_op(OP_MSUB, SEL_MUL, 32'd2, 32'd3);
        @(posedge clk); #1;
        checks++;
        if (whilo_o !== 1'b1 || hi_o !== 32'd0 || lo_o !== 32'hA) begin
            failures++;
            $display("FAIL msub got whilo=%b hi=%h lo=%h exp 1 0 a", whilo_o, hi_o, lo_o);
        end
        @(posedge clk); #1;
        set_op(OP_MSUBU, SEL_MUL, 32'd1, 32'h20);
        @(posedge clk); #1;
        checks++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFF0) begin
            failures++;
            $display("FAIL msubu got hi=%h lo=%h exp ffffffff fffffff0", hi_o, lo_o);
        end
        @(posedge clk); #1;
        set_op(OP_NOP, SEL_NOP, 0, 0);
    endtask

    task automatic test_madd_stall;
        commits = 0;
        stall_i = 1;
        set_op(OP_MADD, SEL_MUL, 32'hFFFFFFFF, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (stallreq_from_ex !== 1'b1 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL madd_idle_hold got stallreq=%b whilo=%b exp 1 0", stallreq_from_ex, whilo_o);
        end
        stall_i = 0;
        #1;
        @(posedge clk); #1;
        stall_i = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (whilo_o && !stall_i) commits++;
            @(posedge clk); #1;
        end
        checks++;
        if (whilo_o !== 1'b1 || stallreq_from_ex !== 1'b0) begin
            failures++;
            $display("FAIL madd_acc_hold got whilo=%b stallreq=%b exp 1 0", whilo_o, stallreq_from_ex);
        end
        stall_i = 0;
        #1;
        if (whilo_o && !stall_i) commits++;
        checks++;
        if (lo_o !== 32'hD || hi_o !== 32'd0) begin
            failures++;
            $display("FAIL madd_stall_val got hi=%h lo=%h exp 0 d", hi_o, lo_o);
        end
        @(posedge clk); #1;
        set_op(OP_NOP, SEL_NOP, 0, 0);
        if (whilo_o && !stall_i) commits++;
        checks++;
        if (commits !== 1) begin
            failures++;
            $display("FAIL madd_single_commit got %0d exp 1", commits);
        end
    endtask

    task automatic test_madd_flush_reset;
        @(posedge clk); #1;
        set_op(OP_MADD, SEL_MUL, 32'hFFFFFFFF, 32'd3);
        @(posedge clk); #1;
        set_op(OP_OR, SEL_LOGIC, 32'h0000FF00, 32'h0F0F0F0F);
        checks++;
        if (wdata_o !== 32'h0F0FFF0F || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_op got wdata=%h whilo=%b exp 0f0fff0f 0", wdata_o, whilo_o);
        end
        @(posedge clk); #1;
        set_op(OP_MADD, SEL_MUL, 32'hFFFFFFFF, 32'd3);
        checks++;
        if (stallreq_from_ex !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle got stallreq=%b exp 1", stallreq_from_ex);
        end
        @(posedge clk); #1;
        rst = 0;
        #1;
        checks++;
        if (whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL madd_rst_nowrite got whilo=%b exp 0", whilo_o);
        end
        rst = 1;
        #1;
        checks++;
        if (stallreq_from_ex !== 1'b1 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL madd_rst_restart got stallreq=%b whilo=%b exp 1 0", stallreq_from_ex, whilo_o);
        end
        @(posedge clk); #1;
        checks++;
        if (whilo_o !== 1'b1 || lo_o !== 32'hD) begin
            failures++;
            $display("FAIL madd_rst_commit got whilo=%b lo=%h exp 1 d", whilo_o, lo_o);
        end
        set_op(OP_NOP, SEL_NOP, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0; commits = 0;
        clk = 0; rst = 0;
        aluop_i = 0; alusel_i = 0; reg1_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0;
        hi_i = 0; lo_i = 0; mem_whilo_i = 0; mem_hi_i = 0; mem_lo_i = 0;
        wb_whilo_i = 0; wb_hi_i = 0; wb_lo_i = 0; stall_i = 0;
        #2;
        test_reset;
        test_logic;
        test_shift;
        test_arith;
        test_move;
        test_mult;
        test_unknown;
        test_madd;
        test_madd_stall;
        test_madd_flush_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex.md
Name: ex

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the decode stage, via the id_ex pipeline register, and consumes aluop/alusel/reg1/reg2/wd/wreg.
- Computes logic, shift, arithmetic, move and multiply results, with HI/LO forwarding from the mem and wb stages.
- MADD/MADDU/MSUB/MSUBU are two-cycle operations sequenced by an internal state machine. The block requests a pipeline stall for the first cycle.

Parameters:
- DW, 32, datapath width (equals RegBus).
- AW, 5, register address width (equals RegAddrBus).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- aluop_i  in  8  operation code from decode (AluOpBus)
- alusel_i  in  3  result class (AluSelBus)
- reg1_i  in  DW  source operand 1
- reg2_i  in  DW  source operand 2
- wd_i  in  AW  destination register
- wreg_i  in  1  destination write enable
- hi_i / lo_i  in  DW  committed HI/LO
- mem_whilo_i, mem_hi_i, mem_lo_i  in  1/DW/DW  HI/LO write from mem stage
- wb_whilo_i, wb_hi_i, wb_lo_i  in  1/DW/DW  HI/LO write from wb stage
- stall_i  in  1  ex stage held by a later stage
- wd_o  out  AW  destination register
- wreg_o  out  1  write enable
- wdata_o  out  DW  GPR result
- whilo_o  out  1  HI/LO write enable
- hi_o / lo_o  out  DW  HI/LO write data
- ov_o  out  1  signed overflow detected
- stallreq_from_ex  out  1  stall request to pipeline control

Behaviour:
- rst low:
  - all outputs 0.
  - state = IDLE; hilo_temp (64b) = 0.
- Outputs are combinational from inputs and state. Latency 0 for all ops except the MADD family.
- HI/LO source priority: mem stage > wb stage > hi_i/lo_i.
- LOGIC class: OR, AND, XOR, NOR.
- SHIFT class:
  - shift amount = reg1_i[4:0].
  - SLL and SRL are logical; SRA is arithmetic (sign-fill).
- ARITHMETIC class:
  - ADD, ADDU, ADDI, ADDIU, SUB, SUBU.
  - SLT is signed compare; SLTU is unsigned compare.
  - CLZ and CLO operate on reg1_i; an all-zero input to CLZ gives 32.
- MOVE class:
  - MFHI/MFLO return the forwarded HI/LO.
  - MTHI sets whilo_o=1, hi_o=reg1_i, lo_o=forwarded LO.
  - MTLO is symmetric to MTHI.
  - MOVN/MOVZ: wdata_o=reg1_i; wreg_o passes through wreg_i.
- MUL class:
  - MUL writes the low 32 bits of the signed product to the GPR.
  - MULT/MULTU set whilo_o=1 with the 64-bit product; wreg_o=0.
- Unknown aluop: wdata_o=0, whilo_o=0; wd_o/wreg_o pass through.
- DIV/DIVU: no effect here (reserved for the div block).
- MADD-family FSM, states IDLE and ACC:
  - IDLE with MADD-family op and stall_i=0: register the product (negated for MSUB/MSUBU) into hilo_temp, stallreq_from_ex=1, whilo_o=0, go to ACC.
  - ACC: {hi_o,lo_o} = hilo_temp + forwarded {HI,LO}, whilo_o=1, stallreq_from_ex=0, go to IDLE.
  - stall_i=1 holds state and hilo_temp in either state; outputs are recomputed but the state does not advance.
  - Non-MADD op while in ACC (flush): return to IDLE; the op executes normally.
  - Reset mid-operation: IDLE immediately; no HI/LO write.
- The 64-bit signed product is computed as an unsigned multiply of operand magnitudes followed by a conditional two's-complement negate.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined:
  - ADD/ADDI/SUB with signed overflow force wreg_o=0 and ov_o=1.
  - Overflow = operand signs equal and result sign differs (for SUB, compare after negating reg2).
- Undefined:
  - ov_o tied 0.
  - ADD/ADDI/SUB always write the wrapped result, identical to the unsigned variants.

Decomposition:
- Opcode, aluop and alusel codes, and bus widths belong in the shared defines.v include.
- New entries there: ExStIdle, ExStAcc, DoubleRegBus (63:0).
- Sub-module ex_mul: combinational 32x32 signed/unsigned multiplier with a signed_i select, producing 64 bits. Shared by MUL, MULT/MULTU and the MADD family.

Test Plan:
- OR, reg1=0x0000FF00, reg2=0x0F0F0F0F, wd_i=5, wreg_i=1 -> same cycle wdata_o=0x0F0F FF0F, wd_o=5, wreg_o=1.
- SRA, reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001. SLT, reg1=0xFFFFFFFF, reg2=1 -> wdata_o=1. SLTU with the same operands -> wdata_o=0.
- MFHI with hi_i=1, wb_whilo=1/wb_hi=0x5555, mem_whilo=1/mem_hi=0xAAAA0000 -> wdata_o=0xAAAA0000. Drop mem_whilo -> 0x5555.
- MULT with reg1=0xFFFFFFFE, reg2=3:
  - whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, wreg_o=0.
  - Under MULTU with the same operands: hi_o=2, lo_o=0xFFFFFFFA.
- MADD with {HI,LO}=0x10, reg1=0xFFFFFFFF, reg2=3:
  - cycle1: stallreq=1, whilo=0.
  - cycle2: stallreq=0, whilo=1, hi_o=0, lo_o=0xD.
  - With stall_i=1 for 3 cycles in ACC: a single commit after stall_i falls.
  - With rst low after cycle1: FSM in IDLE; reissued MADD starts again with stallreq=1.
- ADD, reg1=0x7FFFFFFF, reg2=1:
  - with EX_OVF_TRAP_EN: wreg_o=0, ov_o=1.
  - without: wreg_o=1, wdata_o=0x80000000, ov_o=0.
